beep_pcm_ctrl: RTL and testbench

BEEP_PCM_CTRL -- requirements
Module: beep_pcm_ctrl

---
 rtl/beep_pcm_ctrl.sv | 153 +++++++++++++++
 tb/tb_beep_pcm_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/beep_pcm_ctrl.sv
// Terminal beep generator: 48 kHz sample strobe from clk50, tone/envelope FSM, 16-bit PCM.
// Define BEEP_ENVELOPE_EN for ramped attack/release; otherwise the tone switches on/off in one sample.
module beep_pcm_ctrl #(
    parameter logic [15:0] AMP_MAX     = 16'h2000,
    parameter logic [15:0] AMP_STEP    = 16'h0100,
    parameter int          TONE_HALF   = 24,
    parameter int          MIN_SAMPLES = 4800
) (
    input  logic        clk50,
    input  logic        reset_n,
    input  logic        beep_req,
    input  logic        mute,
    output logic        sample_stb,
    output logic [15:0] pcm_l,
    output logic [15:0] pcm_r,
    output logic        busy
);

    localparam int                CNT_W    = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TONE_HALF - 1);
    localparam logic [12:0]       LEN_MAX  = 13'(MIN_SAMPLES);

    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

    state_t                 state, state_n;
    logic        [11:0]     acc;
    logic        [12:0]     acc_sum;
    logic                   tick;
    logic        [15:0]     amp, amp_n;
    logic        [12:0]     len, len_n;
    logic                   pol, pol_n;
    logic        [CNT_W-1:0] cnt, cnt_n;
    logic signed [15:0]     pcm_n;

    function automatic logic [12:0] len_sat(input logic [12:0] l);
        return (l >= LEN_MAX) ? LEN_MAX : l + 13'd1;
    endfunction

    function automatic logic signed [15:0] pcm_sel(input logic silent, input logic p,
                                                   input logic [15:0] a);
        logic signed [15:0] mag;
        mag = signed'(a);
        if (silent)
            return '0;
        return p ? mag : -mag;
    endfunction

    // 3/3125 of the 50 MHz clock gives exactly 48 kHz
    assign acc_sum = {1'b0, acc} + 13'd3;
    assign tick    = (acc_sum >= 13'd3125);

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            sample_stb <= 1'b0;
        end else begin
            sample_stb <= tick;
            acc        <= tick ? 12'(acc_sum - 13'd3125) : acc_sum[11:0];
        end
    end

`ifdef BEEP_ENVELOPE_EN
    logic [16:0] amp_up;
    assign amp_up = {1'b0, amp} + {1'b0, AMP_STEP};
`endif

    always_comb begin
        state_n = state;
        amp_n   = amp;
        len_n   = len;
        pol_n   = pol;
        cnt_n   = cnt;
        if (state != IDLE) begin
            len_n = len_sat(len);
            if (cnt == CNT_LAST) begin
                cnt_n = '0;
                pol_n = ~pol;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
        case (state)
            IDLE: if (beep_req) begin
                state_n = ATTACK;
`ifdef BEEP_ENVELOPE_EN
                amp_n   = AMP_STEP;
`else
                amp_n   = AMP_MAX;
`endif
                len_n   = '0;
                pol_n   = 1'b1;
                cnt_n   = '0;
            end
            ATTACK: begin
`ifdef BEEP_ENVELOPE_EN
                if (amp_up >= {1'b0, AMP_MAX}) begin
                    amp_n   = AMP_MAX;
                    state_n = SUSTAIN;
                end else begin
                    amp_n   = amp_up[15:0];
                end
`else
                state_n = SUSTAIN;
`endif
            end
            SUSTAIN: if (!beep_req && len >= LEN_MAX) begin
`ifdef BEEP_ENVELOPE_EN
                state_n = RELEASE;
`else
                state_n = IDLE;
                amp_n   = '0;
`endif
            end
            RELEASE: begin
                // retrigger keeps the current amplitude so the ramp restarts without a click
                if (beep_req) begin
                    state_n = ATTACK;
                    len_n   = '0;
                end else if (amp <= AMP_STEP) begin
                    amp_n   = '0;
                    state_n = IDLE;
                end else begin
                    amp_n   = amp - AMP_STEP;
                end
            end
            default: state_n = IDLE;
        endcase
        pcm_n = pcm_sel((state_n == IDLE) || mute, pol_n, amp_n);
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            amp   <= '0;
            len   <= '0;
            pol   <= 1'b1;
            cnt   <= '0;
            pcm_l <= '0;
            pcm_r <= '0;
            busy  <= 1'b0;
        end else if (tick) begin
            state <= state_n;
            amp   <= amp_n;
            len   <= len_n;
            pol   <= pol_n;
            cnt   <= cnt_n;
            pcm_l <= pcm_n;
            pcm_r <= pcm_n;
            busy  <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_beep_pcm_ctrl.sv
// Randomized bench for beep_pcm_ctrl with a tick-level behavioural model and per-cycle compare.
module tb_beep_pcm_ctrl;

    localparam logic [15:0] P_MAX  = 16'h2000;
    localparam logic [15:0] P_STEP = 16'h0800;
    localparam int          P_HALF = 3;
    localparam int          P_MIN  = 12;
`ifdef BEEP_ENVELOPE_EN
    localparam bit ENV = 1'b1;
`else
    localparam bit ENV = 1'b0;
`endif

    logic        clk50    = 1'b0;
    logic        reset_n  = 1'b0;
    logic        beep_req = 1'b0;
    logic        mute     = 1'b0;
    logic        sample_stb;
    logic [15:0] pcm_l, pcm_r;
    logic        busy;

    always #10 clk50 = ~clk50;

    beep_pcm_ctrl #(
        .AMP_MAX    (P_MAX),
        .AMP_STEP   (P_STEP),
        .TONE_HALF  (P_HALF),
        .MIN_SAMPLES(P_MIN)
    ) dut (
        .clk50     (clk50),
        .reset_n   (reset_n),
        .beep_req  (beep_req),
        .mute      (mute),
        .sample_stb(sample_stb),
        .pcm_l     (pcm_l),
        .pcm_r     (pcm_r),
        .busy      (busy)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Model: mode 0 silent, 1 rising, 2 holding, 3 falling; ph = tick index within one tone period
    longint      edge_n = 0;
    int          m_mode = 0, m_amp = 0, m_len = 0, m_ph = 0;
    logic        m_stb  = 1'b0;
    logic [15:0] m_pcm  = '0;
    logic        m_busy = 1'b0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_tick(input bit req, input bit mt);
        int old_len;
        old_len = m_len;
        if (m_mode == 0) begin
            if (req) begin
                m_mode = 1;
                m_amp  = ENV ? int'(P_STEP) : int'(P_MAX);
                m_len  = 0;
                m_ph   = 0;
            end
        end else begin
            m_ph  = (m_ph + 1) % (2 * P_HALF);
            m_len = (old_len + 1 > P_MIN) ? P_MIN : old_len + 1;
            case (m_mode)
                1: if (!ENV || m_amp + int'(P_STEP) >= int'(P_MAX)) begin
                       m_amp  = P_MAX;
                       m_mode = 2;
                   end else m_amp += P_STEP;
                2: if (!req && old_len >= P_MIN) begin
                       if (ENV) m_mode = 3;
                       else begin m_mode = 0; m_amp = 0; end
                   end
                3: if (req) begin
                       m_mode = 1;
                       m_len  = 0;
                   end else if (m_amp <= int'(P_STEP)) begin
                       m_amp  = 0;
                       m_mode = 0;
                   end else m_amp -= P_STEP;
                default: m_mode = 0;
            endcase
        end
        m_busy = (m_mode != 0);
        m_pcm  = (m_mode == 0 || mt) ? 16'h0000 : ((m_ph < P_HALF) ? 16'(m_amp) : 16'(-m_amp));
    endtask

    always @(posedge clk50 or negedge reset_n) begin
        bit tk;
        if (!reset_n) begin
            edge_n = 0; m_mode = 0; m_amp = 0; m_len = 0; m_ph = 0;
            m_stb = 1'b0; m_pcm = '0; m_busy = 1'b0;
        end else begin
            edge_n++;
            tk    = ((3 * edge_n) / 3125) != ((3 * (edge_n - 1)) / 3125);
            m_stb = tk;
            if (tk) model_tick(beep_req, mute);
        end
    end

    always @(negedge clk50) begin
        if (chk_en) begin
            check("sample_stb", {15'b0, sample_stb}, {15'b0, m_stb});
            check("pcm_l", pcm_l, m_pcm);
            check("pcm_r", pcm_r, m_pcm);
            check("busy", {15'b0, busy}, {15'b0, m_busy});
        end
    end

    task automatic measure_first_stb(input string nm);
        int e = 0;
        do begin
            @(posedge clk50);
            e++;
            #1;
        end while (sample_stb !== 1'b1 && e < 1200);
        check(nm, 16'(e), 16'd1042);
    endtask

    task automatic wait_tick();
        int n = 0;
        @(posedge clk50);
        do begin
            @(negedge clk50);
            n++;
        end while (sample_stb !== 1'b1 && n < 1200);
        check("tick_seen", {15'b0, sample_stb}, 16'd1);
    endtask

    initial begin
        #15;
        reset_n = 1'b1;
        chk_en  = 1'b1;
        measure_first_stb("first_stb_edge");
        check("idle_pcm", pcm_l, 16'h0000);
        check("idle_busy", {15'b0, busy}, 16'd0);

        // directed beep: request for two ticks, then let it run out
        beep_req = 1'b1;
        wait_tick();
        check("start_pcm", pcm_l, ENV ? 16'h0800 : 16'h2000);
        check("start_busy", {15'b0, busy}, 16'd1);
        wait_tick();
        beep_req = 1'b0;
        repeat (2) wait_tick();
        check("tick3_neg_pcm", pcm_l, 16'hE000);
        repeat (9) wait_tick();
        check("tick12_busy", {15'b0, busy}, 16'd1);
        repeat (4) wait_tick();
        check("tick16_busy", {15'b0, busy}, 16'd0);
        check("tick16_pcm", pcm_l, 16'h0000);

        // random request/mute activity, changing at arbitrary cycles
        repeat (45 * 1042) begin
            @(negedge clk50);
            if ($urandom_range(0, 299) == 0) beep_req = ~beep_req;
            if ($urandom_range(0, 2999) == 0) mute = ~mute;
        end

        // reset in the middle of an active beep
        mute     = 1'b0;
        beep_req = 1'b1;
        repeat (2) wait_tick();
        check("pre_reset_busy", {15'b0, busy}, 16'd1);
        #5;
        reset_n = 1'b0;
        #1;
        check("rst_pcm_l", pcm_l, 16'h0000);
        check("rst_pcm_r", pcm_r, 16'h0000);
        check("rst_busy", {15'b0, busy}, 16'd0);
        check("rst_stb", {15'b0, sample_stb}, 16'd0);
        beep_req = 1'b0;
        repeat (3) @(posedge clk50);
        @(negedge clk50);
        #3;
        reset_n = 1'b1;
        measure_first_stb("post_reset_first_stb");
        repeat (3) @(negedge clk50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
